// File: rtl/rtype_seq_ctrl.sv
// rtype_seq_ctrl: multicycle sequencer for the R-type datapath.
// Accepts one instruction per handshake, reads rs/rt, waits ALU_LAT cycles,
// then issues a single register-bank write of the ALU result to rd.
module rtype_seq_ctrl #(
    parameter int ALU_LAT = 1,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Inst_valid,
    input  logic [31:0]       Inst,
    output logic              Inst_ready,
    output logic [ADDR_W-1:0] RA1,
    output logic [ADDR_W-1:0] RA2,
    output logic [5:0]        ALUOp,
    input  logic [DATA_W-1:0] ALU_Res,
    output logic [ADDR_W-1:0] AW,
    output logic [DATA_W-1:0] Di,
    output logic              RegWrite,
    output logic              Done,
    output logic              Err,
    output logic              Busy
);

    // The execute counter is 4 bits, so the wait must fit in 1..15.
    generate
        if (ALU_LAT < 1 || ALU_LAT > 15) begin : g_bad_lat
            $error("rtype_seq_ctrl: ALU_LAT must be in 1..15");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt;
    logic [4:0] rs_q, rt_q, rd_q;
    logic [5:0] funct_q;
    logic       legal;
    logic       xfer;

    // Decode: the six supported R-type functs, or the all-zero NOP word.
    always_comb begin
        legal = 1'b0;
        if (Inst == 32'h0) begin
            legal = 1'b1;
        end else if (Inst[31:26] == 6'h00) begin
            case (Inst[5:0])
                6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A: legal = 1'b1;
                default:                                  legal = 1'b0;
            endcase
        end
    end

    assign Inst_ready = (state_q == IDLE) && !rst;
    assign Busy       = (state_q != IDLE);
    assign xfer       = Inst_valid && Inst_ready;

    // State register; reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state: illegal words are consumed in IDLE without leaving it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (xfer && legal) state_d = READ;
            READ:    state_d = EXEC;
            EXEC:    if (cnt == 4'd0) state_d = WB;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered datapath outputs, counter and latched instruction fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            rs_q     <= '0;
            rt_q     <= '0;
            rd_q     <= '0;
            funct_q  <= '0;
            cnt      <= '0;
            RA1      <= '0;
            RA2      <= '0;
            ALUOp    <= '0;
            AW       <= '0;
            Di       <= '0;
            RegWrite <= 1'b0;
            Done     <= 1'b0;
            Err      <= 1'b0;
        end else begin
            RegWrite <= 1'b0;
            Done     <= 1'b0;
            Err      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (xfer) begin
                        if (legal) begin
                            rs_q    <= Inst[25:21];
                            rt_q    <= Inst[20:16];
                            rd_q    <= Inst[15:11];
                            funct_q <= Inst[5:0];
                        end else begin
                            Err <= 1'b1;
                        end
                    end
                end
                READ: begin
                    RA1   <= ADDR_W'(rs_q);
                    RA2   <= ADDR_W'(rt_q);
                    ALUOp <= funct_q;
                    cnt   <= 4'(ALU_LAT - 1);
                end
                EXEC: begin
                    // Counter stops at zero; the result is captured on the last wait cycle.
                    if (cnt == 4'd0) Di  <= ALU_Res;
                    else             cnt <= cnt - 4'd1;
                end
                WB: begin
                    AW       <= ADDR_W'(rd_q);
                    RegWrite <= (rd_q != 5'd0);  // $zero is never written
                    Done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rtype_seq_ctrl.sv
// Directed self-checking bench for rtype_seq_ctrl (ALU_LAT=1 and ALU_LAT=4 instances).
module tb_rtype_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        Inst_valid = 1'b0;
    logic [31:0] Inst = '0;
    logic [31:0] ALU_Res = '0;

    logic        a_ready, a_we, a_done, a_err, a_busy;
    logic [4:0]  a_ra1, a_ra2, a_aw;
    logic [5:0]  a_op;
    logic [31:0] a_di;

    logic        b_ready, b_we, b_done, b_err, b_busy;
    logic [4:0]  b_ra1, b_ra2, b_aw;
    logic [5:0]  b_op;
    logic [31:0] b_di;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rtype_seq_ctrl #(.ALU_LAT(1)) u_a (
        .clk(clk), .rst(rst), .Inst_valid(Inst_valid), .Inst(Inst), .Inst_ready(a_ready),
        .RA1(a_ra1), .RA2(a_ra2), .ALUOp(a_op), .ALU_Res(ALU_Res), .AW(a_aw), .Di(a_di),
        .RegWrite(a_we), .Done(a_done), .Err(a_err), .Busy(a_busy)
    );

    rtype_seq_ctrl #(.ALU_LAT(4)) u_b (
        .clk(clk), .rst(rst), .Inst_valid(Inst_valid), .Inst(Inst), .Inst_ready(b_ready),
        .RA1(b_ra1), .RA2(b_ra2), .ALUOp(b_op), .ALU_Res(ALU_Res), .AW(b_aw), .Di(b_di),
        .RegWrite(b_we), .Done(b_done), .Err(b_err), .Busy(b_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full LAT=1 sequence on instance a: transfer, then check the retire cycle.
    task automatic run_a(input string tag, input logic [31:0] ins, input logic [31:0] res,
                         input logic exp_we);
        Inst = ins; ALU_Res = res; Inst_valid = 1'b1;
        step();                       // transfer edge T
        Inst_valid = 1'b0;
        chk({tag, "_busy"}, a_busy, 1);
        step(); step();               // T+1 READ->EXEC, T+2 EXEC->WB
        chk({tag, "_we_early"}, a_we, 0);
        step();                       // T+3 retire
        chk({tag, "_done"}, a_done, 1);
        chk({tag, "_we"},   a_we,   exp_we);
        chk({tag, "_err"},  a_err,  0);
        step();
        chk({tag, "_done_off"}, a_done, 0);
    endtask

    initial begin
        int pulses;

        // 1. Reset
        rst = 1'b1;
        step(); step();
        chk("rst_we",    a_we,    0);
        chk("rst_done",  a_done,  0);
        chk("rst_err",   a_err,   0);
        chk("rst_busy",  a_busy,  0);
        chk("rst_ready", a_ready, 0);
        chk("rst_di",    a_di,    0);
        rst = 1'b0;
        #1;
        chk("rel_ready", a_ready, 1);

        // 2. add $21,$1,$2 with result 25
        Inst = 32'h0022A820; ALU_Res = 32'd25; Inst_valid = 1'b1;
        step();                                   // T
        Inst_valid = 1'b0; Inst = 32'hDEADBEEF;   // word may change after transfer
        chk("add_ready_T", a_ready, 0);
        step();                                   // T+1
        chk("add_ra1", a_ra1, 1);
        chk("add_ra2", a_ra2, 2);
        chk("add_op",  a_op,  32'h20);
        step();                                   // T+2
        chk("add_we_T2", a_we, 0);
        step();                                   // T+3
        chk("add_we",   a_we,   1);
        chk("add_aw",   a_aw,   21);
        chk("add_di",   a_di,   25);
        chk("add_done", a_done, 1);
        chk("add_ready_T3", a_ready, 1);
        step();
        chk("add_we_off", a_we, 0);

        // 3. Back-to-back sub $22,$3,$4 then or $23,$5,$6 with valid held
        Inst = 32'h0064B022; ALU_Res = 32'd7; Inst_valid = 1'b1;
        step();                                   // T: sub taken
        Inst = 32'h00A6B825;
        chk("b2b_ready_T", a_ready, 0);
        step();
        chk("b2b_ready_T1", a_ready, 0);
        chk("b2b_op_sub", a_op, 32'h22);
        step();
        chk("b2b_ready_T2", a_ready, 0);
        step();                                   // T+3: first write
        chk("b2b_we1", a_we, 1);
        chk("b2b_aw1", a_aw, 22);
        chk("b2b_di1", a_di, 7);
        ALU_Res = 32'd9;
        step();                                   // T+4: or taken
        Inst_valid = 1'b0;
        chk("b2b_we_gap", a_we, 0);
        chk("b2b_ready_T4", a_ready, 0);
        step();
        chk("b2b_op_or", a_op, 32'h25);
        step();
        chk("b2b_we_gap2", a_we, 0);
        step();                                   // T+7: second write
        chk("b2b_we2", a_we, 1);
        chk("b2b_aw2", a_aw, 23);
        chk("b2b_di2", a_di, 9);
        step();

        // 4. Illegal words: lw (op 0x23) and jr (funct 0x08)
        Inst = 32'h8C220004; Inst_valid = 1'b1;
        step();
        Inst_valid = 1'b0;
        chk("lw_err",   a_err,   1);
        chk("lw_we",    a_we,    0);
        chk("lw_done",  a_done,  0);
        chk("lw_busy",  a_busy,  0);
        chk("lw_ready", a_ready, 1);
        step();
        chk("lw_err_off", a_err, 0);
        Inst = 32'h03E00008; Inst_valid = 1'b1;
        step();
        Inst_valid = 1'b0;
        chk("jr_err",   a_err,   1);
        chk("jr_done",  a_done,  0);
        chk("jr_ready", a_ready, 1);
        step();
        chk("jr_err_off", a_err, 0);
        chk("jr_we",      a_we,  0);

        // 5. Write to $zero and NOP retire without a write
        run_a("zero", 32'h00220020, 32'd3, 1'b0);
        run_a("nop",  32'h00000000, 32'd5, 1'b0);

        // 6. ALU_LAT=4: reset in the 2nd EXEC cycle, then a normal instruction
        rst = 1'b1; step(); rst = 1'b0;
        Inst = 32'h0022A820; ALU_Res = 32'd33; Inst_valid = 1'b1;
        step();                                   // T
        Inst_valid = 1'b0;
        step();                                   // T+1: 1st EXEC cycle
        chk("lat4_op", b_op, 32'h20);
        step();                                   // T+2: 2nd EXEC cycle
        chk("lat4_busy_exec", b_busy, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("lat4_rst_busy", b_busy, 0);
        chk("lat4_rst_di",   b_di,   0);
        chk("lat4_rst_ra1",  b_ra1,  0);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (b_we || b_done || b_err) pulses++;
        end
        chk("lat4_no_pulse", pulses, 0);

        Inst = 32'h0064B022; ALU_Res = 32'd44; Inst_valid = 1'b1;
        step();                                   // T
        Inst_valid = 1'b0;
        pulses = 0;
        for (int i = 1; i <= 5; i++) begin
            step();
            if (b_we || b_done) pulses++;
        end
        chk("lat4_early", pulses, 0);
        step();                                   // T+6
        chk("lat4_we",   b_we,   1);
        chk("lat4_aw",   b_aw,   22);
        chk("lat4_di",   b_di,   44);
        chk("lat4_done", b_done, 1);
        step();
        chk("lat4_we_off", b_we,    0);
        chk("lat4_ready",  b_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
